bd_output_packer: RTL and testbench

- Sits directly downstream of the BD output decoder/deserializer.
- Consumes decoded BD words ({leaf_code, payload}) and packs them into 32-bit host-bound words for the FPGA→PC output FIFO.
- Narrow leaves go out as one word; wide leaves are split into two words.
- Words with invalid leaf codes are dropped and counted.

---
 rtl/bd_output_packer_if.sv | 34 +++
 rtl/bd_output_packer.sv | 88 ++++++++
 tb/tb_bd_output_packer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/bd_output_packer_if.sv
// Handshake bundle between the BD decoder, the output packer and the host FIFO.
// The packer takes the slave side; its environment drives the master side.
interface bd_output_packer_if #(
    parameter int NCODE    = 4,
    parameter int NPAYLOAD = 38
);
    logic [NCODE-1:0]    in_leaf_code;
    logic [NPAYLOAD-1:0] in_payload;
    logic                in_v;
    logic                in_a;
    logic [31:0]         out_d;
    logic                out_v;
    logic                out_a;

    modport slave (
        input  in_leaf_code,
        input  in_payload,
        input  in_v,
        output in_a,
        output out_d,
        output out_v,
        input  out_a
    );

    modport master (
        output in_leaf_code,
        output in_payload,
        output in_v,
        input  in_a,
        input  out_d,
        input  out_v,
        output out_a
    );
endinterface

// File: rtl/bd_output_packer.sv
// Packs decoded BD words into 32-bit host words; wide leaves take two words.
// Invalid leaf codes are swallowed and counted in a saturating counter.
module bd_output_packer #(
    parameter int                     NCODE          = 4,
    parameter int                     NPAYLOAD       = 38,
    parameter logic [(1<<NCODE)-1:0]  WIDE_MASK      = 16'h18C1,
    parameter int                     MAX_VALID_CODE = 12,
    parameter int                     NCNT           = 16
) (
    input  logic             clk,
    input  logic             reset,
    bd_output_packer_if.slave bus,
    output logic [NCNT-1:0]  drop_count
);
    localparam int HIW = NPAYLOAD - 27;
    localparam logic [NCODE-1:0] MAXC = NCODE'(MAX_VALID_CODE);

    typedef enum logic [1:0] {
        EMPTY,
        FIRST,
        SECOND
    } state_e;

    state_e              state_q;
    logic [NCODE-1:0]    code_q;
    logic [NPAYLOAD-1:0] payload_q;
    logic [NCNT-1:0]     drop_q;
    logic [NCNT-1:0]     drop_d;

    logic        hold_v;
    logic        phase;
    logic        last_now;
    logic        accept;
    logic        code_ok;
    logic        load;
    logic [26:0] chunk;

    assign hold_v   = (state_q != EMPTY);
    assign phase    = (state_q == SECOND);
    assign last_now = phase || !WIDE_MASK[code_q];

    // Reset forces in_a low so nothing is transferred while held in reset.
    assign bus.in_a = reset && (!hold_v || (bus.out_a && last_now));
    assign accept   = bus.in_v && bus.in_a;
    assign code_ok  = (bus.in_leaf_code <= MAXC);
    assign load     = accept && code_ok;

    assign chunk = phase ? {{(27-HIW){1'b0}}, payload_q[NPAYLOAD-1:27]}
                         : payload_q[26:0];

    assign bus.out_v = hold_v;
    assign bus.out_d = hold_v ? {code_q, last_now, chunk} : 32'd0;

    assign drop_d = (accept && !code_ok && (drop_q != {NCNT{1'b1}}))
                  ? drop_q + 1'b1
                  : drop_q;

    assign drop_count = drop_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= EMPTY;
            code_q    <= '0;
            payload_q <= '0;
            drop_q    <= '0;
        end else begin
            drop_q <= drop_d;
            // Any accepted valid word lands in FIRST: in_a already implies
            // the previous word's last beat is leaving this edge.
            if (load) begin
                state_q   <= FIRST;
                code_q    <= bus.in_leaf_code;
                payload_q <= bus.in_payload;
            end else begin
                unique case (state_q)
                    EMPTY: state_q <= EMPTY;
                    FIRST,
                    SECOND: begin
                        if (bus.out_a) begin
                            state_q <= last_now ? EMPTY : SECOND;
                        end
                    end
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bd_output_packer.sv
// Randomized and directed bench for bd_output_packer with a queue-based model.
module tb_bd_output_packer;
    localparam logic [15:0] WM = 16'h18C1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] drop;
    logic [3:0]  drop2;

    always #5 clk = ~clk;

    bd_output_packer_if u_if ();
    bd_output_packer_if u_if2 ();

    bd_output_packer u_dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (u_if.slave),
        .drop_count (drop)
    );

    bd_output_packer #(.NCNT(4)) u_sat (
        .clk        (clk),
        .reset      (reset),
        .bus        (u_if2.slave),
        .drop_count (drop2)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] q[$];
    logic [31:0] seen[$];
    logic [15:0] mdrop = '0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_d = '0;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit          ea;
        logic [3:0]  c;
        logic [37:0] p;
        c = u_if.in_leaf_code;
        p = u_if.in_payload;
        if (!reset) begin
            chk("in_a_in_reset", 32'(u_if.in_a), 32'd0);
            q.delete();
            mdrop = '0;
            prev_hold = 1'b0;
        end else begin
            ea = (q.size() == 0) || (u_if.out_a && q.size() == 1);
            chk("out_v", 32'(u_if.out_v), 32'(q.size() != 0));
            chk("in_a", 32'(u_if.in_a), 32'(ea));
            chk("drop_count", 32'(drop), 32'(mdrop));
            if (prev_hold) chk("out_d_stable", u_if.out_d, prev_d);
            if (u_if.out_v && u_if.out_a && q.size() != 0) begin
                chk("out_d", u_if.out_d, q[0]);
                seen.push_back(u_if.out_d);
                void'(q.pop_front());
            end
            if (u_if.in_v && u_if.in_a) begin
                if (c > 4'd12) begin
                    if (mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
                end else if (WM[c]) begin
                    q.push_back({c, 1'b0, p[26:0]});
                    q.push_back({c, 1'b1, 16'b0, p[37:27]});
                end else begin
                    q.push_back({c, 1'b1, p[26:0]});
                end
            end
            prev_hold = u_if.out_v && !u_if.out_a;
            prev_d = u_if.out_d;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(bit a, int n);
        u_if.in_v = 1'b0;
        u_if.out_a = a;
        repeat (n) cyc();
    endtask

    task automatic send(logic [3:0] c, logic [37:0] p, bit a);
        bit acc;
        acc = 1'b0;
        u_if.in_v = 1'b1;
        u_if.in_leaf_code = c;
        u_if.in_payload = p;
        u_if.out_a = a;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = u_if.in_a;
            cyc();
        end
        u_if.in_v = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        u_if.in_v = 1'b0;
        u_if.in_leaf_code = '0;
        u_if.in_payload = '0;
        u_if.out_a = 1'b0;
        u_if2.in_v = 1'b0;
        u_if2.in_leaf_code = 4'd15;
        u_if2.in_payload = '0;
        u_if2.out_a = 1'b1;

        repeat (3) cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_out_v", 32'(u_if.out_v), 32'd0);
        chk("rst_out_d", u_if.out_d, 32'd0);
        chk("rst_in_a", 32'(u_if.in_a), 32'd1);
        chk("rst_drop", 32'(drop), 32'd0);
        cyc();

        seen.delete();
        u_if.out_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            u_if.in_v = 1'b1;
            u_if.in_leaf_code = 4'd8;
            u_if.in_payload = 38'hABC + 38'(i);
            cyc();
        end
        idle(1'b1, 2);
        chk("narrow_count", 32'(seen.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++)
            chk("narrow_word", seen[i], 32'h8800_0ABC + 32'(i));

        seen.delete();
        send(4'd0, 38'h3F_FFFF_FFFF, 1'b1);
        idle(1'b1, 3);
        chk("wide_count", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            chk("wide_w0", seen[0], 32'h07FF_FFFF);
            chk("wide_w1", seen[1], 32'h0800_07FF);
        end

        seen.delete();
        send(4'd12, 38'hDE_ADBE_EF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", u_if.out_d, 32'hC6AD_BEEF);
            cyc();
        end
        idle(1'b1, 3);
        chk("bp_count", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            chk("bp_w0", seen[0], 32'hC6AD_BEEF);
            chk("bp_w1", seen[1], 32'hC800_001B);
        end

        seen.delete();
        send(4'd3, 38'd1, 1'b1);
        send(4'd13, 38'd9, 1'b1);
        send(4'd8, 38'd2, 1'b1);
        send(4'd14, 38'd9, 1'b1);
        send(4'd15, 38'd9, 1'b1);
        send(4'd5, 38'd3, 1'b1);
        idle(1'b1, 3);
        chk("drop3", 32'(drop), 32'd3);
        chk("inv_count", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            chk("inv_w0", seen[0], 32'h3800_0001);
            chk("inv_w1", seen[1], 32'h8800_0002);
            chk("inv_w2", seen[2], 32'h5800_0003);
        end

        seen.delete();
        send(4'd6, 38'h2A_1234_5678, 1'b0);
        idle(1'b1, 1);
        reset = 1'b0;
        idle(1'b0, 2);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_v", 32'(u_if.out_v), 32'd0);
        chk("mid_rst_drop", 32'(drop), 32'd0);
        cyc();
        send(4'd8, 38'd7, 1'b1);
        idle(1'b1, 2);
        chk("mid_rst_count", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            chk("mid_rst_w0", seen[0], 32'h6234_5678);
            chk("mid_rst_w1", seen[1], 32'h8800_0007);
        end

        for (int i = 0; i < 3000; i++) begin
            u_if.in_v = ($urandom_range(3) != 0);
            u_if.out_a = ($urandom_range(2) != 0);
            u_if.in_leaf_code = 4'($urandom_range(15));
            u_if.in_payload = {6'($urandom), 32'($urandom)};
            cyc();
        end
        idle(1'b1, 5);
        chk("drain_empty", 32'(q.size()), 32'd0);

        u_if2.in_v = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("sat_15", 32'(drop2), 32'd15);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("sat_hold", 32'(drop2), 32'd15);
        chk("sat_out_v", 32'(u_if2.out_v), 32'd0);
        u_if2.in_v = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
